// File: rtl/pulse_proto_pkg.sv
// Shared definitions for the pulse-parameter serial protocol:
// control codes, frame length, sender state encoding and checksum.
package pulse_proto_pkg;

  localparam logic [7:0] CONT_SET_DELAY    = 8'd0;
  localparam logic [7:0] CONT_SET_PERIOD   = 8'd1;
  localparam logic [7:0] CONT_SET_PULSE1   = 8'd2;
  localparam logic [7:0] CONT_SET_PULSE2   = 8'd3;
  localparam logic [7:0] CONT_SET_BLOCK    = 8'd4;
  localparam logic [7:0] CONT_SET_CPMG     = 8'd5;
  localparam logic [7:0] CONT_SET_ATT      = 8'd6;
  localparam logic [7:0] CONT_SET_NUTATION = 8'd7;

  localparam int unsigned FRAME_BYTES = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_TX_START,
    ST_TX_END,
    ST_GAP,
    ST_WAIT_ACK
  } sender_state_t;

  // Echo checksum covers the four data bytes only, wrapping at 8 bits.
  function automatic logic [7:0] data_checksum(input logic [31:0] d);
    logic [7:0] s;
    s = d[7:0] + d[15:8] + d[23:16] + d[31:24];
    return s;
  endfunction

endpackage

// File: rtl/pulse_cmd_sender_if.sv
// Command, UART byte port and status signals of pulse_cmd_sender.
// master = the sender block, slave = command source / UART side.
interface pulse_cmd_sender_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_ctrl;
  logic [31:0] cmd_data;
  logic        transmit;
  logic [7:0]  tx_byte;
  logic        is_transmitting;
  logic        received;
  logic [7:0]  rx_byte;
  logic        recv_error;
  logic        busy;
  logic        done;
  logic        ack_ok;
  logic [7:0]  ack_byte;
  logic        timeout;

  modport master (
    input  cmd_valid, cmd_ctrl, cmd_data, is_transmitting, received, rx_byte, recv_error,
    output cmd_ready, transmit, tx_byte, busy, done, ack_ok, ack_byte, timeout
  );

  modport slave (
    output cmd_valid, cmd_ctrl, cmd_data, is_transmitting, received, rx_byte, recv_error,
    input  cmd_ready, transmit, tx_byte, busy, done, ack_ok, ack_byte, timeout
  );
endinterface

// File: rtl/pulse_cmd_sender.sv
// Serializes a 32-bit parameter plus control code as five UART bytes,
// then waits for the checksum echo and reports match, mismatch or timeout.
module pulse_cmd_sender
  import pulse_proto_pkg::*;
#(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd2_000_000,
  parameter logic [7:0]  GAP_CYCLES     = 8'd0
) (
  input  logic               clk,
  input  logic               reset,
  pulse_cmd_sender_if.master bus
);

  sender_state_t r_state, w_next;
  logic [31:0] r_data;
  logic [7:0]  r_ctrl;
  logic [7:0]  r_exp_sum;
  logic [2:0]  r_idx;
  logic [7:0]  r_gap_cnt;
  logic [31:0] r_timer;
  logic        r_done;
  logic        r_ack_ok;
  logic [7:0]  r_ack_byte;
  logic        r_timeout;

  logic       w_ready, w_accept, w_active, w_expire, w_echo, w_timeout_hit;
  logic       w_transmit, w_gap_done, w_last_byte;
  logic [7:0] w_cur_byte;

  assign w_ready     = (r_state == ST_IDLE) & ~reset;
  assign w_accept    = bus.cmd_valid & w_ready;
  assign w_active    = (r_state != ST_IDLE) & (r_state != ST_LOAD);
  // Expiry fires on the last counted cycle so done lands exactly TIMEOUT_CYCLES after the first transmit.
  assign w_expire    = w_active & (r_timer == TIMEOUT_CYCLES - 32'd1);
  assign w_echo      = (r_state == ST_WAIT_ACK) & bus.received & ~bus.recv_error;
  assign w_timeout_hit = w_expire & ~w_echo;
  assign w_gap_done  = (r_gap_cnt == GAP_CYCLES);
  assign w_last_byte = (r_idx == 3'(FRAME_BYTES - 1));

  always_comb begin
    w_cur_byte = r_ctrl;
    case (r_idx)
      3'd0:    w_cur_byte = r_data[7:0];
      3'd1:    w_cur_byte = r_data[15:8];
      3'd2:    w_cur_byte = r_data[23:16];
      3'd3:    w_cur_byte = r_data[31:24];
      default: w_cur_byte = r_ctrl;
    endcase
  end

  always_comb begin
    w_next     = r_state;
    w_transmit = 1'b0;
    case (r_state)
      ST_IDLE:     if (w_accept) w_next = ST_LOAD;
      ST_LOAD:     w_next = ST_SEND;
      ST_SEND: begin
        if (w_expire) begin
          w_next = ST_IDLE;
        end else if (!bus.is_transmitting) begin
          w_transmit = 1'b1;
          w_next     = ST_TX_START;
        end
      end
      ST_TX_START: begin
        if (w_expire)                  w_next = ST_IDLE;
        else if (bus.is_transmitting)  w_next = ST_TX_END;
      end
      ST_TX_END: begin
        if (w_expire)                  w_next = ST_IDLE;
        else if (!bus.is_transmitting) w_next = ST_GAP;
      end
      ST_GAP: begin
        if (w_expire)        w_next = ST_IDLE;
        else if (w_gap_done) w_next = w_last_byte ? ST_WAIT_ACK : ST_SEND;
      end
      ST_WAIT_ACK: begin
        if (w_echo || w_expire) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_data     <= '0;
      r_ctrl     <= '0;
      r_exp_sum  <= '0;
      r_idx      <= '0;
      r_gap_cnt  <= '0;
      r_timer    <= '0;
      r_done     <= 1'b0;
      r_ack_ok   <= 1'b0;
      r_ack_byte <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_done    <= w_echo | w_timeout_hit;
      r_gap_cnt <= (r_state == ST_GAP) ? r_gap_cnt + 8'd1 : '0;
      if (w_accept) begin
        r_data    <= bus.cmd_data;
        r_ctrl    <= bus.cmd_ctrl;
        r_exp_sum <= data_checksum(bus.cmd_data);
        r_idx     <= '0;
        r_timer   <= '0;
      end else if (w_active) begin
        r_timer <= r_timer + 32'd1;
      end
      if (r_state == ST_GAP && w_gap_done && !w_last_byte && !w_expire)
        r_idx <= r_idx + 3'd1;
      if (w_echo) begin
        r_ack_byte <= bus.rx_byte;
        r_ack_ok   <= (bus.rx_byte == r_exp_sum);
        r_timeout  <= 1'b0;
      end else if (w_timeout_hit) begin
        r_ack_ok  <= 1'b0;
        r_timeout <= 1'b1;
      end
    end
  end

  assign bus.cmd_ready = w_ready;
  assign bus.transmit  = w_transmit;
  assign bus.tx_byte   = w_transmit ? w_cur_byte : '0;
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.done      = r_done;
  assign bus.ack_ok    = r_ack_ok;
  assign bus.ack_byte  = r_ack_byte;
  assign bus.timeout   = r_timeout;

endmodule

// File: tb/tb_pulse_cmd_sender.sv
// Self-checking bench for pulse_cmd_sender: UART responder, frame/result
// model built from the protocol rules, and directed command scenarios.
module tb_pulse_cmd_sender;

  localparam int TO_CYC   = 1000;
  localparam int GAP_CYC  = 2;
  localparam int BYTE_CYC = 8;

  typedef struct {
    logic       ok;
    logic [7:0] ab;
    logic       to;
    bit         chk_lat;
  } res_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pulse_cmd_sender_if bus();

  pulse_cmd_sender #(
    .TIMEOUT_CYCLES(32'd1000),
    .GAP_CYCLES    (8'd2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int tx_count = 0;
  int done_count = 0;
  int first_tx_cyc = 0;
  int frame_pos = 0;
  int low_cyc = 0;
  int uart_seen = 0;
  int ucnt = 0;
  logic uart_hold = 1'b0;
  logic prev_tx = 1'b0;
  logic prev_istx = 1'b0;
  logic [7:0] last_ack = 8'h00;
  logic [7:0] exp_bytes[$];
  logic [7:0] sent_log[$];
  res_t exp_res[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] model_sum(input logic [31:0] d);
    int s = 0;
    for (int i = 0; i < 4; i++) s += int'((d >> (8 * i)) & 32'hFF);
    return 8'(s % 256);
  endfunction

  task automatic push_frame(input logic [7:0] ctrl, input logic [31:0] d);
    for (int i = 0; i < 4; i++) exp_bytes.push_back(8'((d >> (8 * i)) & 32'hFF));
    exp_bytes.push_back(ctrl);
  endtask

  task automatic expect_res(input logic ok, input logic [7:0] ab, input logic to, input bit lat);
    res_t r;
    r.ok = ok; r.ab = ab; r.to = to; r.chk_lat = lat;
    exp_res.push_back(r);
  endtask

  // UART transmitter stand-in: busy for BYTE_CYC cycles starting the cycle after each transmit.
  initial begin
    bus.is_transmitting = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (tx_count != uart_seen) begin
        uart_seen = tx_count;
        ucnt = BYTE_CYC;
      end else if (ucnt > 0) begin
        ucnt--;
      end
      bus.is_transmitting = uart_hold || (ucnt > 0);
    end
  end

  // Compare process: every transmitted byte and every done against the model.
  initial begin
    res_t r;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (bus.transmit) begin
          chk("tx_while_uart_busy", bus.is_transmitting, 0);
          chk("tx_held_two_cycles", prev_tx, 0);
          chk("tx_byte_expected", exp_bytes.size() > 0, 1);
          if (exp_bytes.size() > 0) chk("tx_byte", bus.tx_byte, exp_bytes.pop_front());
          if (frame_pos == 0) first_tx_cyc = cyc;
          else chk("gap_idle_cycles", (cyc - low_cyc) > GAP_CYC, 1);
          frame_pos = (frame_pos + 1) % 5;
          sent_log.push_back(bus.tx_byte);
          tx_count++;
        end
        if (bus.done) begin
          done_count++;
          chk("done_expected", exp_res.size() > 0, 1);
          if (exp_res.size() > 0) begin
            r = exp_res.pop_front();
            chk("ack_ok", bus.ack_ok, r.ok);
            chk("ack_byte", bus.ack_byte, r.ab);
            chk("timeout", bus.timeout, r.to);
            chk("busy_at_done", bus.busy, 0);
            if (r.chk_lat) chk("timeout_latency", cyc - first_tx_cyc, TO_CYC);
          end
        end
      end
      if (prev_istx && !bus.is_transmitting) low_cyc = cyc;
      prev_istx = bus.is_transmitting;
      prev_tx = bus.transmit;
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_cmd(input logic [7:0] ctrl, input logic [31:0] d);
    chk("cmd_ready_before_accept", bus.cmd_ready, 1);
    push_frame(ctrl, d);
    bus.cmd_ctrl = ctrl;
    bus.cmd_data = d;
    bus.cmd_valid = 1'b1;
    step(1);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic pulse_rx(input logic [7:0] b, input logic err);
    bus.rx_byte = b;
    bus.recv_error = err;
    bus.received = 1'b1;
    step(1);
    bus.received = 1'b0;
    bus.recv_error = 1'b0;
  endtask

  task automatic wait_tx(input int n, input string nm);
    int k = 0;
    while (tx_count < n && k < 3000) begin step(1); k++; end
    chk(nm, tx_count >= n, 1);
  endtask

  task automatic wait_done(input int n, input string nm);
    int k = 0;
    while (done_count < n && k < 2000) begin step(1); k++; end
    chk(nm, done_count >= n, 1);
  endtask

  task automatic wait_line_idle();
    int k = 0;
    step(2);
    while (bus.is_transmitting && k < 200) begin step(1); k++; end
    chk("line_idle_wait", bus.is_transmitting, 0);
    step(GAP_CYC + 4);
  endtask

  task automatic check_last5(input string nm, input logic [39:0] lit);
    int base;
    logic [7:0] b;
    base = sent_log.size() - 5;
    for (int i = 0; i < 5; i++) begin
      b = lit[39 - 8 * i -: 8];
      if (base >= 0) chk(nm, sent_log[base + i], b);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int tx0, d0;
    reset = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_ctrl = '0;
    bus.cmd_data = '0;
    bus.received = 1'b0;
    bus.rx_byte = '0;
    bus.recv_error = 1'b0;

    chk("model_sum_2710", model_sum(32'h0000_2710), 8'h37);
    chk("model_sum_wrap", model_sum(32'hFFFF_FFFF), 8'hFC);

    step(3);
    @(negedge clk);
    chk("rst_cmd_ready", bus.cmd_ready, 0);
    chk("rst_transmit", bus.transmit, 0);
    chk("rst_tx_byte", bus.tx_byte, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_ack_ok", bus.ack_ok, 0);
    chk("rst_ack_byte", bus.ack_byte, 0);
    chk("rst_timeout", bus.timeout, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", bus.cmd_ready, 1);
    step(1);

    // Stray echo while idle
    pulse_rx(8'h37, 1'b0);
    step(3);
    chk("stray_idle_no_done", done_count, 0);

    // Period command, correct echo; stray echo during byte 2
    tx0 = tx_count;
    send_cmd(pulse_proto_pkg::CONT_SET_PERIOD, 32'h0000_2710);
    wait_tx(tx0 + 3, "t1_three_bytes");
    pulse_rx(8'h37, 1'b0);
    wait_tx(tx0 + 5, "t1_five_bytes");
    wait_line_idle();
    chk("t1_no_early_done", done_count, 0);
    expect_res(1'b1, 8'h37, 1'b0, 1'b0);
    last_ack = 8'h37;
    pulse_rx(8'h37, 1'b0);
    wait_done(1, "t1_done");
    @(negedge clk);
    chk("t1_ack_ok_lit", bus.ack_ok, 1);
    chk("t1_ack_byte_lit", bus.ack_byte, 8'h37);
    chk("t1_done_one_cycle", bus.done, 0);
    check_last5("t1_byte_order", 40'h10_27_00_00_01);
    step(1);

    // All-ones data, wrong echo
    send_cmd(pulse_proto_pkg::CONT_SET_ATT, 32'hFFFF_FFFF);
    wait_tx(tx0 + 10, "t2_five_bytes");
    wait_line_idle();
    expect_res(1'b0, 8'hFD, 1'b0, 1'b0);
    last_ack = 8'hFD;
    pulse_rx(8'hFD, 1'b0);
    wait_done(2, "t2_done");
    @(negedge clk);
    chk("t2_ack_ok_lit", bus.ack_ok, 0);
    chk("t2_ack_byte_lit", bus.ack_byte, 8'hFD);
    chk("t2_timeout_lit", bus.timeout, 0);
    step(1);

    // Framing-error byte in WAIT_ACK is ignored, then good echo
    send_cmd(pulse_proto_pkg::CONT_SET_PERIOD, 32'h0000_2710);
    wait_tx(tx0 + 15, "t3_five_bytes");
    wait_line_idle();
    pulse_rx(8'h37, 1'b1);
    step(3);
    chk("t3_err_no_done", done_count, 2);
    expect_res(1'b1, 8'h37, 1'b0, 1'b0);
    last_ack = 8'h37;
    pulse_rx(8'h37, 1'b0);
    wait_done(3, "t3_done");
    step(1);

    // Echo during last byte on the line is ignored; transaction times out
    send_cmd(pulse_proto_pkg::CONT_SET_DELAY, 32'h1234_5678);
    wait_tx(tx0 + 20, "t4_five_bytes");
    step(2);
    chk("t4_line_busy", bus.is_transmitting, 1);
    pulse_rx(model_sum(32'h1234_5678), 1'b0);
    expect_res(1'b0, last_ack, 1'b1, 1'b1);
    wait_done(4, "t4_done");
    @(negedge clk);
    chk("t4_ready_after_timeout", bus.cmd_ready, 1);
    chk("t4_timeout_lit", bus.timeout, 1);
    chk("t4_ack_ok_lit", bus.ack_ok, 0);
    step(1);

    // UART back-pressure at accept, plus an ignored second command
    uart_hold = 1'b1;
    step(2);
    send_cmd(pulse_proto_pkg::CONT_SET_PULSE2, 32'h0000_00AA);
    step(3);
    bus.cmd_valid = 1'b1;
    bus.cmd_data = 32'hDEAD_BEEF;
    bus.cmd_ctrl = 8'h07;
    step(1);
    chk("bp_not_ready_while_busy", bus.cmd_ready, 0);
    step(2);
    bus.cmd_valid = 1'b0;
    step(42);
    chk("bp_no_tx_while_held", tx_count, tx0 + 20);
    uart_hold = 1'b0;
    wait_tx(tx0 + 25, "t5_five_bytes");
    wait_line_idle();
    expect_res(1'b1, 8'hAA, 1'b0, 1'b0);
    last_ack = 8'hAA;
    pulse_rx(8'hAA, 1'b0);
    wait_done(5, "t5_done");
    step(20);
    chk("t5_second_cmd_dropped", tx_count, tx0 + 25);

    // Reset during byte 2 TX_END, then a clean frame
    send_cmd(pulse_proto_pkg::CONT_SET_PULSE1, 32'hCAFE_F00D);
    wait_tx(tx0 + 28, "t6_three_bytes");
    step(2);
    reset = 1'b1;
    exp_bytes.delete();
    frame_pos = 0;
    last_ack = 8'h00;
    step(1);
    reset = 1'b0;
    @(negedge clk);
    chk("t6_busy_after_reset", bus.busy, 0);
    chk("t6_transmit_after_reset", bus.transmit, 0);
    chk("t6_ready_after_reset", bus.cmd_ready, 1);
    chk("t6_ack_byte_after_reset", bus.ack_byte, 0);
    chk("t6_ack_ok_after_reset", bus.ack_ok, 0);
    step(1);
    d0 = done_count;
    send_cmd(pulse_proto_pkg::CONT_SET_CPMG, 32'h0102_0304);
    wait_tx(tx0 + 33, "t6_five_bytes");
    wait_line_idle();
    expect_res(1'b1, 8'h0A, 1'b0, 1'b0);
    pulse_rx(8'h0A, 1'b0);
    wait_done(d0 + 1, "t6_done");
    check_last5("t6_byte_order", 40'h04_03_02_01_05);
    step(5);

    chk("model_bytes_drained", exp_bytes.size(), 0);
    chk("model_results_drained", exp_res.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
